// File: rtl/menu_nav_ctrl.sv
// Pushbutton navigation for the OLED menu: debounces up/down/centre/left and owns
// the selection index and active layer. Define MENU_AUTOREPEAT_EN for hold-to-repeat.
module menu_nav_ctrl #(
  parameter int NUM_ITEMS       = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 3000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnC,
  input  logic       btnL,
  output logic [3:0] state,
  output logic [3:0] layer,
  output logic       select_pulse,
  output logic       back_pulse,
  output logic       app_up,
  output logic       app_down
);

  // state  | meaning
  // MENU   | up/down move the selection index, centre opens the app
  // ENTER  | one cycle: layer <= index+1, strobe select_pulse
  // ACTIVE | up/down forwarded as app strobes, left leaves
  // EXIT   | one cycle: layer <= 0, strobe back_pulse
  typedef enum logic [1:0] {S_MENU, S_ENTER, S_ACTIVE, S_EXIT} fsm_t;

  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LOAD  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_ITEMS - 1);

  fsm_t            cur_st, nxt_st;
  logic [3:0]      raw, sync1, sync2, level, level_d, press;
  logic [DB_W-1:0] db_cnt [4];
  logic            up_step, dn_step;
  logic [3:0]      state_n, layer_n;
  logic            sel_n, back_n, up_n, dn_n;

  // bit order: 0 up, 1 down, 2 centre, 3 left
  assign raw = {btnL, btnC, btnD, btnU};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= DB_LOAD;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= DB_LOAD;
        end else if (db_cnt[i] == '0) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= DB_LOAD;
        end else begin
          db_cnt[i] <= db_cnt[i] - DB_W'(1);
        end
      end
    end
  end

`ifdef MENU_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  logic [RP_W-1:0] rep_cnt [2];
  logic [1:0]      rep_arm, rep_pulse;
  logic            fsm_change;

  assign fsm_change = (nxt_st != cur_st);

  // Armed on the press edge; any release or FSM transition drops the hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_arm   <= '0;
      rep_pulse <= '0;
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_pulse[i] <= 1'b0;
        if (!level[i] || fsm_change) begin
          rep_arm[i] <= 1'b0;
          rep_cnt[i] <= '0;
        end else if (!level_d[i]) begin
          rep_arm[i] <= 1'b1;
          rep_cnt[i] <= RP_W'(REPEAT_DELAY - 1);
        end else if (rep_arm[i]) begin
          if (rep_cnt[i] == '0) begin
            rep_pulse[i] <= 1'b1;
            rep_cnt[i]   <= RP_W'(REPEAT_PERIOD - 1);
          end else begin
            rep_cnt[i] <= rep_cnt[i] - RP_W'(1);
          end
        end
      end
    end
  end

  assign up_step = press[0] | rep_pulse[0];
  assign dn_step = press[1] | rep_pulse[1];
`else
  wire unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

  assign up_step = press[0];
  assign dn_step = press[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) cur_st <= S_MENU;
    else       cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_MENU:   if (press[2]) nxt_st = S_ENTER;
      S_ENTER:  nxt_st = S_ACTIVE;
      S_ACTIVE: if (press[3]) nxt_st = S_EXIT;
      S_EXIT:   nxt_st = S_MENU;
      default:  nxt_st = S_MENU;
    endcase
  end

  always_comb begin
    state_n = state;
    layer_n = layer;
    sel_n   = 1'b0;
    back_n  = 1'b0;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    case (cur_st)
      S_MENU: begin
        if (!press[2]) begin
          if (up_step && !dn_step && state != 4'd0)
            state_n = state - 4'd1;
          else if (dn_step && !up_step && state != LAST_IDX)
            state_n = state + 4'd1;
        end
      end
      S_ENTER: begin
        layer_n = state + 4'd1;
        sel_n   = 1'b1;
      end
      S_ACTIVE: begin
        if (!press[3]) begin
          up_n = up_step;
          dn_n = dn_step;
        end
      end
      S_EXIT: begin
        layer_n = 4'd0;
        back_n  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= '0;
      layer        <= '0;
      select_pulse <= 1'b0;
      back_pulse   <= 1'b0;
      app_up       <= 1'b0;
      app_down     <= 1'b0;
    end else begin
      state        <= state_n;
      layer        <= layer_n;
      select_pulse <= sel_n;
      back_pulse   <= back_n;
      app_up       <= up_n;
      app_down     <= dn_n;
    end
  end

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Bench for menu_nav_ctrl: button presses feed a navigation model whose expected
// output events are queued and matched by a negedge monitor.
module tb_menu_nav_ctrl;
  localparam int D    = 4;
  localparam int N    = 6;
  localparam int RD   = 8;
  localparam int RPER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = '0;
  logic [3:0] state, layer;
  logic       select_pulse, back_pulse, app_up, app_down;

  menu_nav_ctrl #(
    .NUM_ITEMS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk), .reset(reset),
    .btnU(btn[0]), .btnD(btn[1]), .btnC(btn[2]), .btnL(btn[3]),
    .state(state), .layer(layer), .select_pulse(select_pulse),
    .back_pulse(back_pulse), .app_up(app_up), .app_down(app_down)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic [3:0] ly;
    logic       sel, bk, up, dn;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // navigation model
  int m_state = 0;
  int m_layer = 0;
  bit m_active = 0;

  function automatic void push(int c, bit sel, bit bk, bit up, bit dn);
    ev_t e;
    e.cyc = c; e.st = 4'(m_state); e.ly = 4'(m_layer);
    e.sel = sel; e.bk = bk; e.up = up; e.dn = dn;
    exp_q.push_back(e);
  endfunction

  // Steps produced by a hold of h cycles: the press step, plus repeats if enabled.
  function automatic int num_steps(int h);
    int n = 1;
`ifdef MENU_AUTOREPEAT_EN
    while (RD + RPER * (n - 1) <= h - 2) n++;
`endif
    return n;
  endfunction

  function automatic int step_time(int k, int j);
    if (j == 0) return k + 4 + D;
    return k + 4 + D + RD + RPER * (j - 1);
  endfunction

  function automatic void model(logic [3:0] m, int k, int h);
    int n = num_steps(h);
    if (!m_active) begin
      if (m[2]) begin
        m_active = 1; m_layer = m_state + 1;
        push(k + 5 + D, 1, 0, 0, 0);
      end else if (m[0] != m[1]) begin
        for (int j = 0; j < n; j++) begin
          int nv = m[0] ? m_state - 1 : m_state + 1;
          if (nv >= 0 && nv <= N - 1) begin
            m_state = nv;
            push(step_time(k, j), 0, 0, 0, 0);
          end
        end
      end
    end else begin
      if (m[3]) begin
        m_active = 0; m_layer = 0;
        push(k + 5 + D, 0, 1, 0, 0);
      end else if (m[0] || m[1]) begin
        for (int j = 0; j < n; j++) push(step_time(k, j), 0, 0, m[0], m[1]);
      end
    end
  endfunction

  task automatic check(string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic [3:0] m, int h);
    int k;
    @(negedge clk);
    k = cyc;
    model(m, k, h);
    btn = m;
    tick(h);
    btn = '0;
    tick(D + 12);
  endtask

  task automatic bounce(int b, int h);
    @(negedge clk);
    btn[b] = 1'b1;
    tick(h);
    btn[b] = 1'b0;
    tick(D + 6);
  endtask

  task automatic check_reset_outputs();
    check("rst_state",  {4'd0, state}, 8'd0);
    check("rst_layer",  {4'd0, layer}, 8'd0);
    check("rst_select", {7'd0, select_pulse}, 8'd0);
    check("rst_back",   {7'd0, back_pulse}, 8'd0);
    check("rst_app_up", {7'd0, app_up}, 8'd0);
    check("rst_app_dn", {7'd0, app_down}, 8'd0);
  endtask

  // monitor: every visible output change or strobe must match the queue head
  logic [3:0] p_state, p_layer;
  ev_t        got;
  always @(negedge clk) begin
    if (reset) begin
      p_state = state;
      p_layer = layer;
    end else if (state != p_state || layer != p_layer || select_pulse || back_pulse
                 || app_up || app_down) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d st=%0d ly=%0d sel=%0b bk=%0b up=%0b dn=%0b, expected no event",
                 cyc, state, layer, select_pulse, back_pulse, app_up, app_down);
      end else begin
        got = exp_q.pop_front();
        if (got.cyc != cyc || got.st !== state || got.ly !== layer || got.sel !== select_pulse
            || got.bk !== back_pulse || got.up !== app_up || got.dn !== app_down) begin
          errors++;
          $display("FAIL event: got cyc=%0d st=%0d ly=%0d sel=%0b bk=%0b up=%0b dn=%0b, expected cyc=%0d st=%0d ly=%0d sel=%0b bk=%0b up=%0b dn=%0b",
                   cyc, state, layer, select_pulse, back_pulse, app_up, app_down,
                   got.cyc, got.st, got.ly, got.sel, got.bk, got.up, got.dn);
        end
      end
      p_state = state;
      p_layer = layer;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tick(3);
    check_reset_outputs();
    reset = 1'b0;
    tick(2);

    press(4'b0001, 6);                         // up at 0 stays 0
    repeat (3) press(4'b0010, 8);              // 0 -> 1 -> 2 -> 3
    repeat (7) press(4'b0010, 6);              // saturates at 5

    for (int i = 0; i < 40; i += 6) begin      // 3-cycle bursts never debounce
      btn[1] = 1'b1; tick(3);
      btn[1] = 1'b0; tick(3);
    end
    tick(D + 6);

    repeat (3) press(4'b0001, 6);              // 5 -> 2
    press(4'b0100, 6);                         // select, layer 3
    press(4'b0010, 6);                         // app_down only
    press(4'b0100, 6);                         // centre ignored while active
    press(4'b1000, 6);                         // back, layer 0, state 2
    press(4'b1000, 6);                         // left ignored in menu
    press(4'b0110, 6);                         // centre beats down
    press(4'b1010, 6);                         // left beats down

    // reset while centre is held
    @(negedge clk);
    k = cyc;
    model(4'b0100, k, 0);
    btn = 4'b0100;
    tick(D + 12);
    reset = 1'b1;
    tick(1);
    check_reset_outputs();
    tick(1);
    reset = 1'b0;
    k = cyc;
    m_state = 0; m_layer = 0; m_active = 0;
    model(4'b0100, k, 0);
    tick(D + 12);
    btn = '0;
    tick(D + 12);
    press(4'b1000, 6);

    press(4'b0010, 34);                        // long hold of down

    repeat (40) begin
      int r;
      int b;
      r = $urandom_range(0, 9);
      b = $urandom_range(0, 3);
      if (r < 2) bounce(b, $urandom_range(1, 3));
      else if (r == 2) press(4'b0011, $urandom_range(5, 8));
      else press(4'(1 << b), $urandom_range(5, 8));
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
